// File: rtl/williams2_pkg.sv
// rtl/williams2_pkg.sv - shared types and constants for the williams2 gun ADC
//
// Purpose: ADC state type, register addresses and bit positions for the
//          control and status registers.
// Ports:   none (package).
package williams2_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } ADC_STATE_T;

  // Register window decode (cpu_addr)
  localparam logic ADC_REG_DATA = 1'b0;
  localparam logic ADC_REG_CTRL = 1'b1;

  // Control register bits (write)
  localparam int CTRL_CH    = 0;
  localparam int CTRL_START = 1;

  // Status register bits (read)
  localparam int ST_BUSY = 7;
  localparam int ST_EOC  = 6;

endpackage

// File: rtl/gun_scale.sv
// rtl/gun_scale.sv - 6-bit gun position to 8-bit ADC code
//
// Purpose: widens a 6-bit position to 8 bits by replicating its top two bits
//          into the low bits (0->00, 63->FF), then optionally inverts.
// Ports:
//   snap_i    in  6  snapshotted gun position
//   scaled_o  out 8  scaled (and optionally inverted) ADC code
module gun_scale #(
  parameter bit INVERT = 1'b0
) (
  input  logic [5:0] snap_i,
  output logic [7:0] scaled_o
);

  logic [7:0] widened;

  assign widened  = {snap_i, snap_i[5:4]};
  assign scaled_o = INVERT ? ~widened : widened;

endmodule

// File: rtl/gun_adc_reader.sv
// rtl/gun_adc_reader.sv - CPU-side emulation of the Turkey Shoot gun ADC
//
// Purpose: snapshots gun_h/gun_v on the rising edge of cnt_4ms and presents
//          them to the CPU through a start / convert / read handshake with an
//          end-of-conversion level flag.
// Ports:
//   clock_12  in  1  system clock, 12 MHz
//   reset_n   in  1  asynchronous active-low reset
//   gun_h     in  6  horizontal gun position
//   gun_v     in  6  vertical gun position
//   cnt_4ms   in  1  4 ms tick; snapshot taken on its rising edge
//   cpu_wr    in  1  single-cycle write strobe
//   cpu_rd    in  1  single-cycle read strobe
//   cpu_addr  in  1  0 = data register, 1 = control/status register
//   cpu_din   in  8  write data
//   cpu_dout  out 8  read data
//   adc_eoc   out 1  end-of-conversion flag
module gun_adc_reader
  import williams2_pkg::*;
#(
  parameter int CONV_CYCLES = 1200,
  parameter bit INVERT_H    = 1'b0,
  parameter bit INVERT_V    = 1'b0
) (
  input  logic       clock_12,
  input  logic       reset_n,
  input  logic [5:0] gun_h,
  input  logic [5:0] gun_v,
  input  logic       cnt_4ms,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  input  logic       cpu_addr,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       adc_eoc
);

  // Loading CONV_CYCLES-1 makes completion land exactly CONV_CYCLES edges
  // after the start write.
  localparam logic [15:0] TIMER_RELOAD = 16'(CONV_CYCLES - 1);

  ADC_STATE_T  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        channel_q, channel_d;
  logic [7:0]  result_q, result_d;
  logic        eoc_q, eoc_d;
  logic [5:0]  snap_h_q, snap_h_d;
  logic [5:0]  snap_v_q, snap_v_d;
  logic        cnt_4ms_q;

  logic [7:0] scaled_h;
  logic [7:0] scaled_v;
  logic       ctrl_wr;
  logic       start_wr;
  logic       data_rd;
  logic [7:0] status;
  logic       unused_din;

  assign unused_din = ^cpu_din[7:2];

  gun_scale #(.INVERT(INVERT_H)) u_scale_h (
    .snap_i   (snap_h_q),
    .scaled_o (scaled_h)
  );

  gun_scale #(.INVERT(INVERT_V)) u_scale_v (
    .snap_i   (snap_v_q),
    .scaled_o (scaled_v)
  );

  assign ctrl_wr  = cpu_wr && (cpu_addr == ADC_REG_CTRL);
  assign start_wr = ctrl_wr && cpu_din[CTRL_START];
  assign data_rd  = cpu_rd && (cpu_addr == ADC_REG_DATA);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    channel_d = channel_q;
    result_d  = result_q;
    eoc_d     = eoc_q;
    snap_h_d  = snap_h_q;
    snap_v_d  = snap_v_q;

    if (cnt_4ms && !cnt_4ms_q) begin
      snap_h_d = gun_h;
      snap_v_d = gun_v;
    end

    // Lowest priority: completion and start below override this clear.
    if (data_rd) begin
      eoc_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start_wr) begin
          channel_d = cpu_din[CTRL_CH];
          timer_d   = TIMER_RELOAD;
          eoc_d     = 1'b0;
          state_d   = CONVERT;
        end else if (ctrl_wr) begin
          channel_d = cpu_din[CTRL_CH];
        end
      end
      CONVERT: begin
        // A restart beats a completion in the same cycle; non-start control
        // writes are dropped while busy.
        if (start_wr) begin
          channel_d = cpu_din[CTRL_CH];
          timer_d   = TIMER_RELOAD;
          eoc_d     = 1'b0;
        end else if (timer_q == 16'd0) begin
          result_d = channel_q ? scaled_v : scaled_h;
          eoc_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_12 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      timer_q   <= 16'd0;
      channel_q <= 1'b0;
      result_q  <= 8'h00;
      eoc_q     <= 1'b0;
      snap_h_q  <= 6'd0;
      snap_v_q  <= 6'd0;
      cnt_4ms_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      channel_q <= channel_d;
      result_q  <= result_d;
      eoc_q     <= eoc_d;
      snap_h_q  <= snap_h_d;
      snap_v_q  <= snap_v_d;
      cnt_4ms_q <= cnt_4ms;
    end
  end

  always_comb begin
    status          = 8'h00;
    status[ST_BUSY] = (state_q == CONVERT);
    status[ST_EOC]  = eoc_q;
    status[CTRL_CH] = channel_q;
  end

  assign cpu_dout = (cpu_addr == ADC_REG_DATA) ? result_q : status;
  assign adc_eoc  = eoc_q;

endmodule

// File: tb/tb_gun_adc_reader.sv
// tb/tb_gun_adc_reader.sv - self-checking bench for gun_adc_reader
module tb_gun_adc_reader;

  logic       clock_12 = 1'b0;
  logic       reset_n  = 1'b0;
  logic [5:0] gun_h    = 6'd0;
  logic [5:0] gun_v    = 6'd0;
  logic       cnt_4ms  = 1'b0;
  logic       cpu_wr   = 1'b0;
  logic       cpu_rd   = 1'b0;
  logic       cpu_addr = 1'b0;
  logic [7:0] cpu_din  = 8'h00;
  logic [7:0] cpu_dout;
  logic       adc_eoc;

  int tests  = 0;
  int failed = 0;

  gun_adc_reader #(
    .CONV_CYCLES (4),
    .INVERT_H    (1'b0),
    .INVERT_V    (1'b1)
  ) dut (
    .clock_12 (clock_12),
    .reset_n  (reset_n),
    .gun_h    (gun_h),
    .gun_v    (gun_v),
    .cnt_4ms  (cnt_4ms),
    .cpu_wr   (cpu_wr),
    .cpu_rd   (cpu_rd),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .adc_eoc  (adc_eoc)
  );

  always #5 clock_12 = ~clock_12;

  typedef struct {
    logic [5:0] h;
    logic [5:0] v;
    logic       ch;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_12);
    #1;
  endtask

  task automatic peek(input logic addr, output logic [7:0] d);
    cpu_addr = addr;
    #1;
    d = cpu_dout;
  endtask

  task automatic snapshot(input logic [5:0] h, input logic [5:0] v);
    gun_h   = h;
    gun_v   = v;
    cnt_4ms = 1'b1;
    tick();
    cnt_4ms = 1'b0;
    tick();
  endtask

  task automatic wr(input logic addr, input logic [7:0] data);
    cpu_wr   = 1'b1;
    cpu_addr = addr;
    cpu_din  = data;
    tick();
    cpu_wr   = 1'b0;
    cpu_din  = 8'h00;
  endtask

  task automatic rd(input logic addr, output logic [7:0] d);
    cpu_rd   = 1'b1;
    cpu_addr = addr;
    #1;
    d = cpu_dout;
    tick();
    cpu_rd = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int         n;

    vecs[0] = '{h: 6'd0,  v: 6'd0,  ch: 1'b0, exp_data: 8'h00};
    vecs[1] = '{h: 6'd63, v: 6'd0,  ch: 1'b0, exp_data: 8'hFF};
    vecs[2] = '{h: 6'd32, v: 6'd0,  ch: 1'b0, exp_data: 8'h82};
    vecs[3] = '{h: 6'd21, v: 6'd0,  ch: 1'b0, exp_data: 8'h55};
    vecs[4] = '{h: 6'd0,  v: 6'd32, ch: 1'b1, exp_data: 8'h7D};
    vecs[5] = '{h: 6'd0,  v: 6'd0,  ch: 1'b1, exp_data: 8'hFF};
    vecs[6] = '{h: 6'd0,  v: 6'd63, ch: 1'b1, exp_data: 8'h00};
    vecs[7] = '{h: 6'd63, v: 6'd42, ch: 1'b1, exp_data: 8'h55};

    // Reset state
    #2;
    peek(1'b0, d); check8("reset_data", d, 8'h00);
    peek(1'b1, d); check8("reset_status", d, 8'h00);
    check1("reset_eoc", adc_eoc, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    peek(1'b1, d); check8("post_reset_status", d, 8'h00);
    wr(1'b0, 8'h03);
    peek(1'b1, d); check8("data_addr_write_ignored", d, 8'h00);

    // h=63 conversion, busy window, read clears eoc
    snapshot(6'd63, 6'd0);
    wr(1'b1, 8'h02);
    peek(1'b1, d); check8("busy_status_0", d, 8'h80);
    for (int i = 1; i < 4; i++) begin
      tick();
      peek(1'b1, d); check8($sformatf("busy_status_%0d", i), d, 8'h80);
      check1($sformatf("eoc_low_%0d", i), adc_eoc, 1'b0);
    end
    tick();
    check1("eoc_high", adc_eoc, 1'b1);
    peek(1'b1, d); check8("done_status", d, 8'h40);
    rd(1'b0, d); check8("h63_data", d, 8'hFF);
    check1("eoc_cleared", adc_eoc, 1'b0);
    peek(1'b1, d); check8("status_after_read", d, 8'h00);

    // Table of scaling / channel vectors
    foreach (vecs[k]) begin
      snapshot(vecs[k].h, vecs[k].v);
      wr(1'b1, {6'b0, 1'b1, vecs[k].ch});
      repeat (3) tick();
      check1($sformatf("vec%0d_eoc_early", k), adc_eoc, 1'b0);
      tick();
      check1($sformatf("vec%0d_eoc", k), adc_eoc, 1'b1);
      peek(1'b1, d); check8($sformatf("vec%0d_status", k), d, {2'b01, 5'b0, vecs[k].ch});
      rd(1'b0, d); check8($sformatf("vec%0d_data", k), d, vecs[k].exp_data);
    end

    // Snapshot must not follow gun_h without a cnt_4ms edge
    snapshot(6'd5, 6'd0);
    gun_h = 6'd10;
    repeat (2) tick();
    wr(1'b1, 8'h02);
    repeat (4) tick();
    rd(1'b0, d); check8("snap_held", d, 8'h14);

    // Restart: second start at cycle 2 retimes and switches channel
    snapshot(6'd63, 6'd42);
    wr(1'b1, 8'h02);
    tick();
    wr(1'b1, 8'h03);
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (adc_eoc) begin
        n = i;
        break;
      end
    end
    check8("restart_latency", 8'(n), 8'd4);
    peek(1'b1, d); check8("restart_status", d, 8'h41);
    rd(1'b0, d); check8("restart_data", d, 8'h55);

    // Data read on the completion edge returns the old result
    snapshot(6'd63, 6'd0);
    wr(1'b1, 8'h02);
    repeat (3) tick();
    rd(1'b0, d); check8("coincident_read_old", d, 8'h55);
    check1("coincident_eoc", adc_eoc, 1'b1);
    peek(1'b0, d); check8("coincident_new_result", d, 8'hFF);

    // Start on the completion edge wins
    snapshot(6'd0, 6'd63);
    wr(1'b1, 8'h02);
    repeat (3) tick();
    wr(1'b1, 8'h03);
    check1("start_wins_eoc", adc_eoc, 1'b0);
    peek(1'b0, d); check8("start_wins_result", d, 8'hFF);
    repeat (4) tick();
    check1("start_wins_final_eoc", adc_eoc, 1'b1);
    peek(1'b0, d); check8("start_wins_final_data", d, 8'h00);

    // Reset mid-conversion: no eoc, result cleared
    snapshot(6'd63, 6'd0);
    wr(1'b1, 8'h02);
    tick();
    reset_n = 1'b0;
    #1;
    check1("midreset_eoc", adc_eoc, 1'b0);
    peek(1'b0, d); check8("midreset_data", d, 8'h00);
    peek(1'b1, d); check8("midreset_status", d, 8'h00);
    tick();
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (adc_eoc) n++;
    end
    check8("midreset_no_eoc", 8'(n), 8'd0);
    peek(1'b0, d); check8("midreset_result", d, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
